// File: rtl/i281_pkg.sv
// i281_pkg: shared i281 instruction field layout, opcodes, one-hot decode indices and fetch states
package i281_pkg;
  localparam int IR_W = 16;
  localparam int OPCODE_W = 27;
  localparam int OH_W = 23;
  localparam int OP_MSB = 15;
  localparam int OP_LSB = 12;
  localparam int RX_MSB = 11;
  localparam int RX_LSB = 10;
  localparam int RY_MSB = 9;
  localparam int RY_LSB = 8;
  localparam int IMM_MSB = 7;
  localparam logic [3:0] OP_NOOP = 4'd0;
  localparam logic [3:0] OP_GCD = 4'd1;
  localparam logic [3:0] OP_MOVE = 4'd2;
  localparam logic [3:0] OP_LOADI = 4'd3;
  localparam logic [3:0] OP_ADD = 4'd4;
  localparam logic [3:0] OP_ADDI = 4'd5;
  localparam logic [3:0] OP_SUB = 4'd6;
  localparam logic [3:0] OP_SUBI = 4'd7;
  localparam logic [3:0] OP_LOAD = 4'd8;
  localparam logic [3:0] OP_LOADF = 4'd9;
  localparam logic [3:0] OP_STORE = 4'd10;
  localparam logic [3:0] OP_STOREF = 4'd11;
  localparam logic [3:0] OP_SHIFT = 4'd12;
  localparam logic [3:0] OP_CMP = 4'd13;
  localparam logic [3:0] OP_JUMP = 4'd14;
  localparam logic [3:0] OP_BR = 4'd15;
  localparam logic [4:0] OH_NOOP = 5'd0;
  localparam logic [4:0] OH_GCD = 5'd1;
  localparam logic [4:0] OH_MOVE = 5'd5;
  localparam logic [4:0] OH_SHIFTL = 5'd15;
  localparam logic [4:0] OH_SHIFTR = 5'd16;
  localparam logic [4:0] OH_CMP = 5'd17;
  localparam logic [4:0] OH_JUMP = 5'd18;
  localparam logic [4:0] OH_BRE = 5'd19;
  localparam logic [4:0] OH_BRGE = 5'd22;
  localparam logic [0:0] ST_IDLE = 1'b0;
  localparam logic [0:0] ST_WAIT = 1'b1;
  // ops MOVE..STOREF occupy consecutive one-hot slots starting at OH_MOVE
  function automatic logic [4:0] oh_index(input logic [3:0] op, input logic [1:0] sub);
    return op == OP_NOOP ? OH_NOOP :
           op == OP_GCD ? OH_GCD + {3'b0, sub} :
           op <= OP_STOREF ? OH_MOVE + {1'b0, op - OP_MOVE} :
           op == OP_SHIFT ? (sub[0] ? OH_SHIFTR : OH_SHIFTL) :
           op == OP_CMP ? OH_CMP :
           op == OP_JUMP ? OH_JUMP : OH_BRE + {3'b0, sub};
  endfunction
endpackage

// File: rtl/instr_decode_reg_if.sv
// instr_decode_reg_if: fetch handshake, imem read port, flags and decoded-instruction bundle
interface instr_decode_reg_if #(parameter int IW = 16);
  logic fetch;
  logic [IW-1:0] imem_data;
  logic imem_valid;
  logic imem_req;
  logic fetch_busy;
  logic flags_we;
  logic [3:0] alu_flags;
  logic [26:0] opcode_in;
  logic [7:0] imm;
  logic [3:0] flags_reg;
  modport master(output fetch, imem_data, imem_valid, flags_we, alu_flags,
                 input imem_req, fetch_busy, opcode_in, imm, flags_reg);
  modport slave(input fetch, imem_data, imem_valid, flags_we, alu_flags,
                output imem_req, fetch_busy, opcode_in, imm, flags_reg);
endinterface

// File: rtl/i281_opdecode.sv
// i281_opdecode: combinational IR to {RX, RY, one-hot instruction} decoder plus immediate
module i281_opdecode
  import i281_pkg::*;
(
  input  logic [IR_W-1:0]     ir,
  output logic [OPCODE_W-1:0] opcode,
  output logic [7:0]          imm
);
  logic [OH_W-1:0] oh;
  assign oh = OH_W'(1) << oh_index(ir[OP_MSB:OP_LSB], ir[RY_MSB:RY_LSB]);
  assign opcode = {ir[RX_MSB:RX_LSB], ir[RY_MSB:RY_LSB], oh};
  assign imm = ir[IMM_MSB:0];
endmodule

// File: rtl/instr_decode_reg.sv
// instr_decode_reg: instruction register with imem fetch handshake, opcode decode and ALU flags register
module instr_decode_reg
  import i281_pkg::*;
#(
  parameter int IW = 16
) (
  input logic             clock,
  input logic             reset_n,
  instr_decode_reg_if.slave bus
);
  logic [0:0] state;
  logic [IW-1:0] ir;
  logic [3:0] flags;
  logic latch;
  // zero-wait memory latches straight from IDLE; fetch seen in WAIT is ignored
  assign latch = (state == ST_WAIT | bus.fetch) & bus.imem_valid;
  always_ff @(posedge clock or negedge reset_n)
    if (!reset_n) begin
      state <= ST_IDLE;
      ir <= '0;
      flags <= '0;
    end else begin
      state <= state == ST_WAIT ? (bus.imem_valid ? ST_IDLE : ST_WAIT) :
               (bus.fetch & !bus.imem_valid ? ST_WAIT : ST_IDLE);
      if (latch) ir <= bus.imem_data;
      if (bus.flags_we) flags <= bus.alu_flags;
    end
  assign bus.imem_req = state == ST_WAIT;
  assign bus.fetch_busy = state == ST_WAIT | (bus.fetch & !bus.imem_valid);
  assign bus.flags_reg = flags;
  i281_opdecode u_dec (
    .ir(ir),
    .opcode(bus.opcode_in),
    .imm(bus.imm)
  );
endmodule

// File: tb/tb_instr_decode_reg.sv
// tb_instr_decode_reg: table-driven decode sweep plus handshake, flags and reset-abort sequences
module tb_instr_decode_reg;
  typedef struct {
    logic [15:0] word;
    logic [26:0] exp;
  } vec_t;
  typedef struct {
    logic [26:0] op;
    logic [7:0] imm;
  } exp_t;
  logic clock = 1'b0;
  logic reset_n = 1'b0;
  int total = 0;
  int bad = 0;
  int base[16] = '{0, 1, 5, 6, 7, 8, 9, 10, 11, 12, 13, 14, 15, 17, 18, 19};
  vec_t vecs[$];
  exp_t sb[$];
  logic [26:0] prev;
  always #5 clock = ~clock;
  instr_decode_reg_if #(.IW(16)) bus();
  instr_decode_reg #(.IW(16)) dut (
    .clock(clock),
    .reset_n(reset_n),
    .bus(bus)
  );
  function automatic logic [26:0] model(input logic [15:0] w);
    int idx;
    idx = base[w[15:12]];
    if (w[15:12] == 4'd1 || w[15:12] == 4'd15) idx += int'(w[9:8]);
    if (w[15:12] == 4'd12) idx += int'(w[8]);
    return {w[11:8], 23'(1) << idx};
  endfunction
  task automatic chk(input string n, input logic [31:0] a, input logic [31:0] e);
    total++;
    if (a !== e) begin
      bad++;
      $display("FAIL %s got=%h want=%h", n, a, e);
    end
  endtask
  task automatic tick();
    @(posedge clock);
    #1;
  endtask
  task automatic push(input logic [26:0] e, input logic [15:0] w);
    sb.push_back('{e, w[7:0]});
  endtask
  task automatic pop_chk(input string n);
    exp_t e;
    total++;
    if (sb.size() == 0) begin
      bad++;
      $display("FAIL %s scoreboard empty got=%h want=entry", n, bus.opcode_in);
    end else begin
      total--;
      e = sb.pop_front();
      chk({n, "_op"}, 32'(bus.opcode_in), 32'(e.op));
      chk({n, "_imm"}, 32'(bus.imm), 32'(e.imm));
      chk({n, "_onehot"}, $countones(bus.opcode_in[22:0]), 32'd1);
    end
  endtask
  initial begin
    bus.fetch = 0;
    bus.imem_valid = 0;
    bus.imem_data = 0;
    bus.flags_we = 0;
    bus.alu_flags = 0;
    #12;
    chk("rst_opcode", 32'(bus.opcode_in), 32'h0000001);
    chk("rst_imm", 32'(bus.imm), 0);
    chk("rst_flags", 32'(bus.flags_reg), 0);
    chk("rst_req", 32'(bus.imem_req), 0);
    chk("rst_busy", 32'(bus.fetch_busy), 0);
    reset_n = 1;
    vecs.push_back('{16'h4600, {4'b0110, 23'h000080}});
    vecs.push_back('{16'hF9A5, {4'b1001, 23'h100000}});
    vecs.push_back('{16'hC133, {4'b0001, 23'h010000}});
    vecs.push_back('{16'h137E, {4'b0011, 23'h000010}});
    for (int op = 0; op < 16; op++)
      for (int s = 0; s < 4; s++) begin
        logic [15:0] w;
        w = {4'(op), 2'($urandom_range(0, 3)), 2'(s), 8'($urandom_range(0, 255))};
        vecs.push_back('{w, model(w)});
      end
    tick();
    foreach (vecs[i]) begin
      bus.fetch = 1;
      bus.imem_valid = 1;
      bus.imem_data = vecs[i].word;
      push(vecs[i].exp, vecs[i].word);
      #1;
      chk("zw_busy", 32'(bus.fetch_busy), 0);
      tick();
      bus.fetch = 0;
      bus.imem_valid = 0;
      pop_chk($sformatf("vec%0d", i));
      chk("zw_req", 32'(bus.imem_req), 0);
    end
    bus.fetch = 1;
    bus.imem_data = 16'h0000;
    #1;
    chk("wait_busy0", 32'(bus.fetch_busy), 1);
    prev = bus.opcode_in;
    tick();
    for (int i = 0; i < 3; i++) begin
      bus.fetch = i == 0;
      if (i == 2) begin
        bus.imem_valid = 1;
        bus.imem_data = 16'hF9A5;
        push({4'b1001, 23'h100000}, 16'hF9A5);
      end
      #1;
      chk("wait_req", 32'(bus.imem_req), 1);
      chk("wait_busy", 32'(bus.fetch_busy), 1);
      chk("wait_hold", 32'(bus.opcode_in), 32'(prev));
      tick();
    end
    bus.imem_valid = 0;
    bus.fetch = 0;
    pop_chk("wait_done");
    chk("wait_req_end", 32'(bus.imem_req), 0);
    chk("wait_busy_end", 32'(bus.fetch_busy), 0);
    bus.fetch = 1;
    bus.imem_valid = 1;
    bus.imem_data = 16'hD03C;
    bus.flags_we = 1;
    bus.alu_flags = 4'b0001;
    push({4'b0000, 23'h020000}, 16'hD03C);
    tick();
    bus.fetch = 0;
    bus.imem_valid = 0;
    bus.alu_flags = 4'b1010;
    pop_chk("flag_latch");
    chk("flag_both", 32'(bus.flags_reg), 32'h1);
    tick();
    bus.flags_we = 0;
    bus.alu_flags = 4'b0110;
    chk("flag_only", 32'(bus.flags_reg), 32'hA);
    chk("flag_ir_hold", 32'(bus.opcode_in), 32'h0020000);
    tick();
    chk("flag_no_we", 32'(bus.flags_reg), 32'hA);
    bus.fetch = 1;
    tick();
    bus.fetch = 0;
    chk("abort_wait", 32'(bus.imem_req), 1);
    reset_n = 0;
    #1;
    chk("abort_req", 32'(bus.imem_req), 0);
    chk("abort_op", 32'(bus.opcode_in), 32'h0000001);
    chk("abort_flags", 32'(bus.flags_reg), 0);
    reset_n = 1;
    bus.imem_valid = 1;
    bus.imem_data = 16'h4600;
    #1;
    chk("late_busy", 32'(bus.fetch_busy), 0);
    tick();
    bus.imem_valid = 0;
    chk("late_op", 32'(bus.opcode_in), 32'h0000001);
    chk("late_imm", 32'(bus.imm), 0);
    chk("late_req", 32'(bus.imem_req), 0);
    chk("sb_drained", sb.size(), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/instr_decode_reg.md
# instr_decode_reg

Instruction register and opcode decoder for the i281 multicycle core: produces the 27-bit `opcode_in` word and the 4-bit `flags_reg` consumed by `controlfsm`. On a fetch strobe from the control FSM it requests a word from instruction memory, waits for it, and latches and decodes it. The word then stays stable for every later state of that instruction. It also owns the ALU flags register written on the control FSM's flag-write strobe.

## Interface
- `IW`, 16: instruction word width.
- `clock` in 1: system clock, rising edge.
- `reset_n` in 1: asynchronous, active-low reset.
- `fetch` in 1: one-cycle fetch strobe from the control FSM in IF.
- `imem_data` in IW: instruction memory read data.
- `imem_valid` in 1: `imem_data` is valid this cycle.
- `imem_req` out 1: instruction memory read request.
- `fetch_busy` out 1: a fetch is outstanding; the control FSM holds in IF/ID while high.
- `flags_we` in 1: flag-write strobe.
- `alu_flags` in 4: ALU flags {V,N,C,Z}, bit 0 = Z.
- `opcode_in` out 27: bits [26:25] RX, [24:23] RY, [22:0] one-hot instruction.
- `imm` out 8: instruction bits [7:0].
- `flags_reg` out 4: registered flags.

## Operation
- Word fields: [15:12] op, [11:10] RX, [9:8] RY/sub, [7:0] imm.
- One-hot decode:
  - op 0: bit 0 (NOOP).
  - op 1: bit 1+sub (bits 1–4, GCD group).
  - ops 2–11: bits 5–14 (MOVE, LOADI/LOADP, ADD, ADDI, SUB, SUBI, LOAD, LOADF, STORE, STOREF).
  - op 12: bit 15 if sub[0]=0 (SHIFTL), else bit 16 (SHIFTR).
  - op 13: bit 17 (CMP).
  - op 14: bit 18 (JUMP).
  - op 15: bit 19+sub (BRE, BRNE, BRG, BRGE).
- Exactly one of bits [22:0] is set after any latch.
- Decode is computed from the registered IR, never from `imem_data` directly.
- FSM states: IDLE, WAIT.
  - IDLE: on `fetch`, assert `imem_req` and go to WAIT.
  - WAIT: hold `imem_req` high. On `imem_valid`, latch IR, drop `imem_req`, go to IDLE.
  - If `imem_valid` arrives in the same cycle `fetch` is seen in IDLE (zero-wait memory), latch immediately and stay in IDLE.
- `fetch_busy` = (state == WAIT) | (IDLE & `fetch` & !`imem_valid`).
- `fetch` while in WAIT is ignored; there are no nested requests.
- `flags_we` loads `alu_flags` into `flags_reg`. It is independent of the fetch FSM and may coincide with an IR latch; both take effect.
- IR changes only on a latch. `opcode_in` and `imm` are stable between latches.
- Reset values:
  - IR = 16'h0000, so `opcode_in` = 27'h0000001 (NOOP, RX=RY=0).
  - `imm` = 0, `flags_reg` = 0, state IDLE.
  - `imem_req` = 0, `fetch_busy` = 0.
- Reset during WAIT aborts the fetch. A late `imem_valid` arriving in IDLE without `fetch` is ignored.

## Timing
- Latency from `fetch` to new `opcode_in`:
  - 1 cycle with zero-wait memory (valid coincident with `fetch`).
  - Otherwise 1 + N cycles after `fetch`, where N is the number of cycles `imem_valid` is delayed.
- `opcode_in` is registered-decoded, combinational from the IR only. It is valid the cycle after the latch edge.
- `flags_reg` updates on the edge where `flags_we` is sampled high and is visible the next cycle. A branch in ID reads flags from the previous CMP's ExALU edge.
- `imem_req` is a registered level. `imem_data` is sampled only when `imem_valid` is high.

## Structure
- Shared package `i281_pkg`:
  - Field widths and bit positions (OP_MSB, RX/RY/IMM positions).
  - Opcode constants OP_NOOP … OP_BR.
  - One-hot index localparams matching `controlfsm` (NOOP=0 … BRGE=22).
  - Fetch state enum.
- One natural sub-module: `i281_opdecode`, the combinational IR → 27-bit decoder, reusable by the single-cycle core.

## Test plan
- Reset with `reset_n`=0 -> `opcode_in`=27'h0000001, `flags_reg`=0, `imem_req`=0.
- `fetch` with `imem_valid` in the same cycle, `imem_data`=16'h4600 (ADD RX=1,RY=2) -> next cycle `opcode_in`[22:0]=bit 7, RX=01, RY=10, `fetch_busy` never set.
- `fetch`, `imem_valid` 3 cycles later with 16'hF9xx (BRNE) -> `imem_req` and `fetch_busy` high for 3 cycles; then bit 20 set; `opcode_in` unchanged during wait.
- Sweep all 16 ops × 4 sub values -> exactly one-hot output matching the index map (16'hC1xx -> bit 16, 16'h13xx -> bit 4).
- `flags_we` with `alu_flags`=4'b0001 while an IR latch occurs -> both `flags_reg`=0001 and the new `opcode_in` visible next cycle.
- `reset_n` pulsed low in WAIT, then `imem_valid` high in IDLE without `fetch` -> IR stays NOOP, `imem_req`=0.
